// File: rtl/cpu_seq_pkg.sv
// Shared constants for the accumulator-CPU program sequencer: opcodes, NOP word,
// FSM state encoding and instruction-word field layout.
package cpu_seq_pkg;

  localparam int WORD_W    = 12;
  localparam int OP_LSB    = 8;
  localparam int OP_W      = 4;
  localparam int DATA_LSB  = 4;
  localparam int DATA_W    = 4;
  localparam int ADDR_LSB  = 0;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 16;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam logic [WORD_W-1:0] NOP_WORD = {OP_NOP, 8'h00};

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ISSUE  = 2'd1,
    SEQ_GAP    = 2'd2,
    SEQ_FINISH = 2'd3
  } seq_state_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // CPU ui_in carries {data, addr}.
  function automatic logic [7:0] ui_of(input logic [WORD_W-1:0] w);
    return {w[DATA_LSB +: DATA_W], w[ADDR_LSB +: ADDR_W]};
  endfunction

  // CPU uio_in carries {opcode, 3'b000, we}; we only for STORE.
  function automatic logic [7:0] uio_of(input logic [WORD_W-1:0] w);
    return {w[OP_LSB +: OP_W], 3'b000, (w[OP_LSB +: OP_W] == OP_STORE)};
  endfunction

endpackage

// File: rtl/cpu_seq_prog_mem.sv
// 16x12 program store: synchronous write, asynchronous read, reset fills NOP.
import cpu_seq_pkg::*;

module cpu_seq_prog_mem (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [3:0]        i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [3:0]        i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= NOP_WORD;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Issues a stored program onto the accumulator CPU command pins and captures the result.
// Optional repeat mode (loop/stop ports) is enabled with SEQ_LOOP_EN.
import cpu_seq_pkg::*;

module cpu_program_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              prog_we,
  input  logic [3:0]        prog_addr,
  input  logic [WORD_W-1:0] prog_word,
  input  logic [4:0]        prog_len,
  input  logic              start,
`ifdef SEQ_LOOP_EN
  input  logic              loop,
  input  logic              stop,
`endif
  input  logic [3:0]        acc_in,
  output logic [7:0]        cpu_ui,
  output logic [7:0]        cpu_uio,
  output logic              busy,
  output logic              done,
  output logic [3:0]        result,
  output logic [3:0]        pc,
  output seq_state_e        dbg_state
);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_pc;
  logic [4:0]        r_len;
  logic              r_loop;
  logic              r_stop;
  logic [7:0]        r_cpu_ui;
  logic [7:0]        r_cpu_uio;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_result;
  logic [3:0]        r_pc_out;

  logic [1:0]        w_state_nx;
  logic [3:0]        w_cnt_nx;
  logic [3:0]        w_pc_nx;
  logic [4:0]        w_len_nx;
  logic              w_loop_nx;
  logic              w_stop_nx;
  logic              w_finish;
  logic              w_busy_nx;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_rdata;
  logic [3:0]        w_raddr;
  logic              w_mem_we;
  logic              w_loop_in;
  logic              w_stop_in;
  logic [4:0]        w_len_sat;
  logic              w_pc_last;
  logic              w_continue;

`ifdef SEQ_LOOP_EN
  assign w_loop_in = loop;
  assign w_stop_in = stop;
`else
  assign w_loop_in = 1'b0;
  assign w_stop_in = 1'b0;
`endif

  assign w_len_sat  = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign w_pc_last  = ({1'b0, r_pc} == (r_len - 5'd1));
  assign w_continue = r_loop & ~(r_stop | w_stop_in);
  // FINISH reads slot 0 so a looping pass can put its first word out in that cycle.
  assign w_raddr    = (r_state == ST_FINISH) ? 4'd0 : r_pc;
  assign w_mem_we   = ena & prog_we & (r_state == ST_IDLE);

  cpu_seq_prog_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_word),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pc_nx    = r_pc;
    w_len_nx   = r_len;
    w_loop_nx  = r_loop;
    w_stop_nx  = r_stop | w_stop_in;
    w_finish   = 1'b0;
    w_busy_nx  = 1'b0;
    w_word     = NOP_WORD;
    case (r_state)
      ST_IDLE: begin
        w_stop_nx = 1'b0;
        if (start) begin
          w_len_nx   = w_len_sat;
          w_loop_nx  = w_loop_in;
          w_stop_nx  = w_stop_in;
          w_pc_nx    = 4'd0;
          w_cnt_nx   = 4'd0;
          w_state_nx = (w_len_sat != 5'd0) ? ST_ISSUE : ST_FINISH;
        end
      end
      ST_ISSUE: begin
        w_word    = w_rdata;
        w_busy_nx = 1'b1;
        if (r_cnt == 4'(HOLD_CYCLES - 1)) begin
          w_cnt_nx   = 4'd0;
          w_state_nx = ST_GAP;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      ST_GAP: begin
        w_busy_nx = 1'b1;
        if (r_cnt == 4'(GAP_CYCLES - 1)) begin
          w_cnt_nx = 4'd0;
          if (w_pc_last) begin
            w_state_nx = ST_FINISH;
          end else begin
            w_pc_nx    = r_pc + 4'd1;
            w_state_nx = ST_ISSUE;
          end
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      default: begin
        w_finish = 1'b1;
        w_pc_nx  = 4'd0;
        // Looping: this cycle is the first hold cycle of the next pass.
        if (w_continue && (r_len != 5'd0)) begin
          w_word     = w_rdata;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = 4'd1;
          w_state_nx = ST_ISSUE;
        end else begin
          w_cnt_nx   = 4'd0;
          w_state_nx = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pc      <= 4'd0;
      r_len     <= 5'd0;
      r_loop    <= 1'b0;
      r_stop    <= 1'b0;
      r_cpu_ui  <= 8'h00;
      r_cpu_uio <= 8'hF0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 4'd0;
      r_pc_out  <= 4'd0;
    end else if (ena) begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pc      <= w_pc_nx;
      r_len     <= w_len_nx;
      r_loop    <= w_loop_nx;
      r_stop    <= w_stop_nx;
      r_cpu_ui  <= ui_of(w_word);
      r_cpu_uio <= uio_of(w_word);
      r_busy    <= w_busy_nx;
      r_done    <= w_finish;
      r_pc_out  <= w_raddr;
      if (w_finish) r_result <= acc_in;
    end
  end

  assign cpu_ui    = r_cpu_ui;
  assign cpu_uio   = r_cpu_uio;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign pc        = r_pc_out;
  assign dbg_state = seq_state_e'(r_state);

endmodule

// File: doc/cpu_program_sequencer.md
# cpu_program_sequencer

Drives the command interface of the 4-bit accumulator CPU from a locally stored program. A host loads up to 16 instruction words, pulses `start`, and the sequencer issues each word onto the CPU's `ui_in`/`uio_in` pins with the pacing the CPU's registered FSM needs. After the last instruction it captures the CPU accumulator (`uo_out[7:4]`) and reports it. It sits between the host or test pins and the CPU: the issuing end of the CPU's command interface.

## Interface
- `HOLD_CYCLES`, default 4: cycles each instruction is held on the bus; legal range 4..15.
- `GAP_CYCLES`, default 2: NOP cycles after each instruction; legal range 1..15.
- `clk` in 1: clock; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: when low, every register holds its value (full freeze).
- `prog_we` in 1: program write strobe.
- `prog_addr` in 4: program slot to write.
- `prog_word` in 12: instruction word `{opcode[11:8], data[7:4], addr[3:0]}`.
- `prog_len` in 5: instruction count; latched at start; values above 16 saturate to 16.
- `start` in 1: single-cycle run request.
- `acc_in` in 4: CPU accumulator, taken from `uo_out[7:4]`.
- `cpu_ui` out 8: drives CPU `ui_in` as `{data, addr}`.
- `cpu_uio` out 8: drives CPU `uio_in` as `{opcode, 3'b000, we}`.
- `busy` out 1: high from the cycle after start is accepted until `done`.
- `done` out 1: one-cycle pulse.
- `result` out 4: captured accumulator.
- `pc` out 4: index of the instruction being issued.

## Operation
- Opcodes: ADD 0, SUB 1, STORE 2, LOAD 3, AND 5, OR 6, XOR 7, SHL 9, SHR A, NOP F.
- `we` is 1 only while a STORE word is driven. NOP drives `cpu_ui`=0 and `cpu_uio`=8'hF0.
- Program memory: 16×12. Reset fills every slot with 12'hF00.
- Program writes are accepted only in IDLE. `prog_we` while `busy` is ignored.
- The FSM has four states:
  - IDLE: outputs NOP. When `start` is sampled, latch `prog_len`, set `pc`=0, then go to ISSUE if the length is nonzero, otherwise FINISH.
  - ISSUE: drive `mem[pc]` for HOLD_CYCLES cycles, then go to GAP.
  - GAP: drive NOP for GAP_CYCLES cycles. Then, if `pc`==len−1, go to FINISH; otherwise increment `pc` and go to ISSUE.
  - FINISH: one cycle. `result`<=`acc_in`, `done`=1, `busy`=0, then go to IDLE.
- `start` in any state other than IDLE is ignored.
- `pc` does not wrap within a run; the maximum is 15.

## Timing
- All outputs are registered.
- Reset values: `cpu_ui`=0, `cpu_uio`=8'hF0, `busy`=0, `done`=0, `result`=0, `pc`=0, state IDLE.
- `start` is sampled at edge S. The first word appears on the buses, and `busy`=1, after edge S+1.
- Each instruction occupies exactly HOLD_CYCLES+GAP_CYCLES cycles.
- `done` is high in the cycle after edge S+1+len·(HOLD_CYCLES+GAP_CYCLES). With defaults and len=3, that is the cycle after edge S+19.
- `acc_in` is sampled in the FINISH cycle. GAP_CYCLES≥1 gives the CPU time to settle after the last instruction.
- If len=0, `done` follows edge S+1 and `result` is refreshed from `acc_in`.
- `ena` low stretches every phase; no cycle is lost or duplicated.
- Reset asserted mid-run aborts the run. Outputs return to reset values and program memory is cleared.
- `prog_we` and `start` in the same IDLE cycle: the write takes effect and the run starts. The run reads the newly written word.

## Configuration
- `SEQ_LOOP_EN` defined:
  - Adds input ports `loop` (latched at start) and `stop`.
  - With `loop` latched high, FINISH pulses `done`, updates `result`, and re-enters ISSUE at `pc`=0 instead of going to IDLE. `busy` stays high.
  - `stop` sampled high at any point makes the current pass end in IDLE after its FINISH.
- `SEQ_LOOP_EN` undefined: the `loop` and `stop` ports are absent, and every run is single-pass.

## Structure
- `cpu_seq_pkg` holds the opcode constants, the NOP word, the state enum, and the instruction-word field positions/widths.
- One sub-module, `cpu_seq_prog_mem`: 16×12 register file with synchronous write, asynchronous read, and reset to NOP.

## Test plan
- Reset → `cpu_uio`=8'hF0, `cpu_ui`=0, `busy`=0, `result`=0, every memory slot reads 12'hF00.
- Load slot 0 with LOAD addr 3 (12'h303) and slot 1 with STORE data 0 addr 5 (12'h205), len=2, start → `cpu_uio`=8'h30 for 4 cycles, then 8'hF0 for 2, then 8'h21 (`we`=1) for 4. `done` follows edge S+13.
- len=3 with `acc_in` held at 4'hA → `done` follows edge S+19, `result`=4'hA, `busy` high for exactly 18 cycles.
- `start` pulsed again mid-run, and `prog_we` to slot 0 mid-run → both ignored; the program and the timing are unchanged.
- `rst_n` low during the second instruction → immediate return to reset values; the next run after reset issues NOP words only.
- With `SEQ_LOOP_EN`, `loop`=1, len=1 → `done` every 6 cycles. `stop` raised → exactly one more `done`, then IDLE.
